// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file writeback control slice.
package rf_ctrl_pkg;
  localparam int REG_AW           = 5;
  localparam int XLEN             = 32;
  localparam int NREGS            = 1 << REG_AW;
  localparam int STARVE_LIMIT_DEF = 3;
  localparam int LONG_MAX_DEF     = 4;
  localparam int LCNT_W           = 3;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_LONG} wb_src_e;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Issue, writeback and register-file port bundle of the writeback arbiter.
interface rf_wb_arbiter_if;
  import rf_ctrl_pkg::*;

  logic              iss_valid;
  logic              iss_long;
  logic [REG_AW-1:0] iss_rd;
  logic [REG_AW-1:0] iss_rs1;
  logic [REG_AW-1:0] iss_rs2;
  logic              iss_use_rs1;
  logic              iss_use_rs2;
  logic              iss_stall;

  logic              wb0_valid;
  logic [REG_AW-1:0] wb0_wa;
  logic [XLEN-1:0]   wb0_wd;

  logic              wb1_valid;
  logic [REG_AW-1:0] wb1_wa;
  logic [XLEN-1:0]   wb1_wd;
  logic              wb1_ready;

  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;
  logic [XLEN-1:0]   rf_wd;

  logic              pipe_hold;
  logic [NREGS-1:0]  busy_vec;
  logic [LCNT_W-1:0] long_cnt;

  // Arbiter side.
  modport slave (
    input  iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2,
    input  wb0_valid, wb0_wa, wb0_wd,
    input  wb1_valid, wb1_wa, wb1_wd,
    output iss_stall, wb1_ready, rf_we, rf_wa, rf_wd, pipe_hold, busy_vec, long_cnt
  );

  // Pipe / long-unit / register-file side.
  modport master (
    output iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2,
    output wb0_valid, wb0_wa, wb0_wd,
    output wb1_valid, wb1_wa, wb1_wd,
    input  iss_stall, wb1_ready, rf_we, rf_wa, rf_wd, pipe_hold, busy_vec, long_cnt
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard, long-op in-flight count and issue stall decision.
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int LONG_MAX = LONG_MAX_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iss_valid,
  input  logic              iss_long,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic              iss_use_rs1,
  input  logic              iss_use_rs2,
  input  logic              wb1_grant,
  input  logic [REG_AW-1:0] wb1_wa,
  output logic              iss_stall,
  output logic [NREGS-1:0]  busy_vec,
  output logic [LCNT_W-1:0] long_cnt
);
  logic [NREGS-1:0]  busy_q, busy_d, clr_mask, set_mask, eff_busy;
  logic [LCNT_W-1:0] cnt_q, cnt_d;
  logic              raw, waw, full, long_fire, dec;

  // Hazard detection against the busy vector with the same-cycle long writeback
  // already retired, since the register file bypasses that write to the reader.
  always_comb begin
    clr_mask  = wb1_grant ? reg_onehot(wb1_wa) : '0;
    eff_busy  = busy_q & ~clr_mask;
    raw       = (iss_use_rs1 & eff_busy[iss_rs1]) | (iss_use_rs2 & eff_busy[iss_rs2]);
    waw       = eff_busy[iss_rd];
    full      = iss_long & (cnt_q == LCNT_W'(LONG_MAX)) & ~wb1_grant;
    iss_stall = iss_valid & (raw | waw | full);
    long_fire = iss_valid & ~iss_stall & iss_long;
  end

  // Next scoreboard state; a new long op to the register being retired wins.
  always_comb begin
    set_mask  = (long_fire && iss_rd != '0) ? reg_onehot(iss_rd) : '0;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
    dec       = wb1_grant & (cnt_q != '0);
    cnt_d     = cnt_q;
    if (long_fire && !dec)      cnt_d = cnt_q + 1'b1;
    else if (!long_fire && dec) cnt_d = cnt_q - 1'b1;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign long_cnt = cnt_q;

  // A long writeback with nothing in flight means the long unit is out of step.
  ap_no_orphan_wb1: assert property (@(posedge clk) disable iff (!rstn)
    !(wb1_grant && cnt_q == '0));
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-source register-file writeback arbiter: pipe has priority, the long unit
// is protected from starvation by a one-cycle registered pipe hold.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int LONG_MAX     = LONG_MAX_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  rf_wb_arbiter_if.slave  bus
);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  logic           wb1_grant, starving, hold_q, hold_d;
  logic [SCW-1:0] starve_cnt, starve_d;
  wb_src_e        src;

  assign bus.wb1_ready = ~bus.wb0_valid;
  assign wb1_grant     = bus.wb1_valid & ~bus.wb0_valid;
  assign starving      = bus.wb1_valid & bus.wb0_valid;

  // Source select: pipe whenever valid, otherwise a ready long writeback.
  always_comb begin
    src = SRC_NONE;
    if (bus.wb0_valid) src = SRC_PIPE;
    else if (wb1_grant) src = SRC_LONG;
  end

  // Register-file write port; x0 writes are suppressed.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wa = '0;
    bus.rf_wd = '0;
    case (src)
      SRC_PIPE: begin
        bus.rf_we = (bus.wb0_wa != '0);
        bus.rf_wa = bus.wb0_wa;
        bus.rf_wd = bus.wb0_wd;
      end
      SRC_LONG: begin
        bus.rf_we = (bus.wb1_wa != '0);
        bus.rf_wa = bus.wb1_wa;
        bus.rf_wd = bus.wb1_wd;
      end
      default: ;
    endcase
  end

  // Starvation count saturates; hold is raised on the edge where the count
  // reaches the limit and dropped again after exactly one cycle.
  always_comb begin
    starve_d = starve_cnt;
    if (!bus.wb1_valid || wb1_grant)                 starve_d = '0;
    else if (starve_cnt != SCW'(STARVE_LIMIT))       starve_d = starve_cnt + 1'b1;
    hold_d = ~hold_q & starving & (starve_cnt >= SCW'(STARVE_LIMIT - 1));
  end

  // Starvation state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
      hold_q     <= 1'b0;
    end else begin
      starve_cnt <= starve_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.pipe_hold = hold_q;

  // The pipe must honour the hold; if it does not, it still wins the port.
  ap_hold_honoured: assert property (@(posedge clk) disable iff (!rstn)
    !(hold_q && bus.wb0_valid));

  rf_scoreboard #(.LONG_MAX(LONG_MAX)) u_sb (
    .clk         (clk),
    .rstn        (rstn),
    .iss_valid   (bus.iss_valid),
    .iss_long    (bus.iss_long),
    .iss_rd      (bus.iss_rd),
    .iss_rs1     (bus.iss_rs1),
    .iss_rs2     (bus.iss_rs2),
    .iss_use_rs1 (bus.iss_use_rs1),
    .iss_use_rs2 (bus.iss_use_rs2),
    .wb1_grant   (wb1_grant),
    .wb1_wa      (bus.wb1_wa),
    .iss_stall   (bus.iss_stall),
    .busy_vec    (bus.busy_vec),
    .long_cnt    (bus.long_cnt)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter with default parameters.
module tb_rf_wb_arbiter;
  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.iss_valid = 0; bus.iss_long = 0; bus.iss_rd = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
    bus.iss_use_rs1 = 0; bus.iss_use_rs2 = 0;
    bus.wb0_valid = 0; bus.wb0_wa = 0; bus.wb0_wd = 0;
    bus.wb1_valid = 0; bus.wb1_wa = 0; bus.wb1_wd = 0;
  endtask

  task automatic iss(input logic lng, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic u1);
    bus.iss_valid = 1; bus.iss_long = lng; bus.iss_rd = rd;
    bus.iss_rs1 = rs1; bus.iss_use_rs1 = u1; bus.iss_rs2 = 0; bus.iss_use_rs2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rstn = 0;
    idle();
    #2;
    chk("rst_busy", 32'(bus.busy_vec), 32'h0);
    chk("rst_cnt", 32'(bus.long_cnt), 0);
    chk("rst_hold", 32'(bus.pipe_hold), 0);
    chk("rst_stall", 32'(bus.iss_stall), 0);
    chk("rst_ready", 32'(bus.wb1_ready), 1);
    chk("rst_we", 32'(bus.rf_we), 0);
    // combinational path still live in reset
    bus.wb0_valid = 1; bus.wb0_wa = 3; bus.wb0_wd = 32'h55;
    #1;
    chk("rst_comb_we", 32'(bus.rf_we), 1);
    chk("rst_comb_wa", 32'(bus.rf_wa), 3);
    chk("rst_comb_rdy", 32'(bus.wb1_ready), 0);
    idle();
    @(negedge clk);
    rstn = 1;
    tick();

    // scoreboard set, RAW stall, release by same-cycle writeback
    iss(1, 5, 0, 0);
    #1 chk("sb_iss_stall", 32'(bus.iss_stall), 0);
    tick();
    chk("sb_busy", 32'(bus.busy_vec), 32'h20);
    chk("sb_cnt", 32'(bus.long_cnt), 1);
    iss(0, 6, 5, 1);
    #1 chk("sb_raw_stall", 32'(bus.iss_stall), 1);
    bus.wb1_valid = 1; bus.wb1_wa = 5; bus.wb1_wd = 32'h1234;
    #1;
    chk("sb_bypass_stall", 32'(bus.iss_stall), 0);
    chk("sb_wb_we", 32'(bus.rf_we), 1);
    chk("sb_wb_wa", 32'(bus.rf_wa), 5);
    chk("sb_wb_wd", bus.rf_wd, 32'h1234);
    tick();
    idle();
    chk("sb_busy_clr", 32'(bus.busy_vec), 0);
    chk("sb_cnt_clr", 32'(bus.long_cnt), 0);

    // pipe priority, then starvation hold
    iss(1, 7, 0, 0);
    tick();
    idle();
    chk("pr_busy", 32'(bus.busy_vec), 32'h80);
    bus.wb0_valid = 1; bus.wb0_wa = 3; bus.wb0_wd = 32'hAAAA;
    bus.wb1_valid = 1; bus.wb1_wa = 7; bus.wb1_wd = 32'h7777;
    #1;
    chk("pr_wa", 32'(bus.rf_wa), 3);
    chk("pr_wd", bus.rf_wd, 32'hAAAA);
    chk("pr_ready", 32'(bus.wb1_ready), 0);
    chk("pr_we", 32'(bus.rf_we), 1);
    tick();
    chk("st_cnt1", 32'(dut.starve_cnt), 1);
    chk("st_hold1", 32'(bus.pipe_hold), 0);
    tick();
    chk("st_cnt2", 32'(dut.starve_cnt), 2);
    chk("st_hold2", 32'(bus.pipe_hold), 0);
    tick();
    chk("st_cnt3", 32'(dut.starve_cnt), 3);
    chk("st_hold3", 32'(bus.pipe_hold), 1);
    bus.wb0_valid = 0;
    #1;
    chk("st_ready", 32'(bus.wb1_ready), 1);
    chk("st_wa", 32'(bus.rf_wa), 7);
    chk("st_wd", bus.rf_wd, 32'h7777);
    tick();
    idle();
    chk("st_cnt0", 32'(dut.starve_cnt), 0);
    chk("st_hold0", 32'(bus.pipe_hold), 0);
    chk("st_busy0", 32'(bus.busy_vec), 0);
    chk("st_lcnt0", 32'(bus.long_cnt), 0);

    // register x0
    bus.wb0_valid = 1; bus.wb0_wa = 0; bus.wb0_wd = 32'h5;
    #1 chk("x0_wb0_we", 32'(bus.rf_we), 0);
    idle();
    iss(1, 0, 0, 0);
    #1 chk("x0_iss_stall", 32'(bus.iss_stall), 0);
    tick();
    idle();
    chk("x0_busy", 32'(bus.busy_vec), 0);
    chk("x0_cnt", 32'(bus.long_cnt), 1);
    bus.wb1_valid = 1; bus.wb1_wa = 0; bus.wb1_wd = 32'h9;
    #1;
    chk("x0_wb1_we", 32'(bus.rf_we), 0);
    chk("x0_wb1_rdy", 32'(bus.wb1_ready), 1);
    tick();
    idle();
    chk("x0_cnt_dec", 32'(bus.long_cnt), 0);

    // fill to LONG_MAX
    for (int r = 1; r <= 4; r++) begin
      iss(1, 5'(r), 0, 0);
      #1 chk("full_fill_stall", 32'(bus.iss_stall), 0);
      tick();
    end
    idle();
    chk("full_cnt", 32'(bus.long_cnt), 4);
    chk("full_busy", 32'(bus.busy_vec), 32'h1E);
    iss(1, 9, 0, 0);
    #1 chk("full_only_stall", 32'(bus.iss_stall), 1);
    iss(1, 1, 0, 0);
    #1 chk("full_waw_stall", 32'(bus.iss_stall), 1);
    bus.wb1_valid = 1; bus.wb1_wa = 1; bus.wb1_wd = 32'h11;
    #1;
    chk("full_grant_stall", 32'(bus.iss_stall), 0);
    chk("full_grant_wa", 32'(bus.rf_wa), 1);
    tick();
    idle();
    chk("full_cnt_hold", 32'(bus.long_cnt), 4);
    chk("full_busy_hold", 32'(bus.busy_vec), 32'h1E);

    // reset mid-operation, no clock edge in between
    bus.wb1_valid = 1; bus.wb1_wa = 5; bus.wb1_wd = 0;
    tick();
    idle();
    chk("pre_rst_cnt", 32'(bus.long_cnt), 3);
    chk("pre_rst_busy", 32'(bus.busy_vec), 32'h1E);
    #1 rstn = 0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy_vec), 0);
    chk("mid_rst_cnt", 32'(bus.long_cnt), 0);
    chk("mid_rst_hold", 32'(bus.pipe_hold), 0);
    chk("mid_rst_starve", 32'(dut.starve_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
